// File: rtl/lia_integrate_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lia_integrate_dump : lock-in integrate-and-dump decimator (signed frames)  |
// | Optional: LIA_ACC_SAT_EN selects saturating instead of wrapping adds.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lia_integrate_dump #(
    parameter int WIN  = 28,
    parameter int WOUT = 64,
    parameter int CW   = 24
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [WIN-1:0]  sig_i,
    input  logic            valid_i,
    input  logic [CW-1:0]   dec_i,
    input  logic            clear_i,
    output logic [WOUT-1:0] sig_o,
    output logic            valid_o,
    output logic            ovf_o
);

    logic [WOUT-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   dec_q, dec_d;
    logic [WOUT-1:0] sig_q, sig_d;
    logic            vld_q, vld_d;
    logic            ovf_q, ovf_d;

    logic            frame_start;
    logic [CW-1:0]   dec_in;
    logic [CW-1:0]   dec_eff;
    logic [WOUT-1:0] base;
    logic [WOUT-1:0] sext;
    logic [WOUT-1:0] raw_sum;
    logic [WOUT-1:0] sum;
    logic            add_ovf;
    logic            last_sample;

    assign frame_start = (cnt_q == '0);
    assign dec_in      = (dec_i == '0) ? CW'(1) : dec_i;
    assign dec_eff     = frame_start ? dec_in : dec_q;
    assign base        = frame_start ? '0 : acc_q;
    assign sext        = {{(WOUT-WIN){sig_i[WIN-1]}}, sig_i};
    assign raw_sum     = base + sext;
    // Same-sign operands producing an opposite-sign result is a signed overflow.
    assign add_ovf     = (base[WOUT-1] == sext[WOUT-1]) && (raw_sum[WOUT-1] != base[WOUT-1]);
    assign last_sample = (cnt_q == dec_eff - CW'(1));

`ifdef LIA_ACC_SAT_EN
    assign sum = !add_ovf       ? raw_sum :
                 base[WOUT-1]   ? {1'b1, {(WOUT-1){1'b0}}} :
                                  {1'b0, {(WOUT-1){1'b1}}};
`else
    assign sum = raw_sum;
`endif

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        dec_d = dec_q;
        sig_d = sig_q;
        vld_d = 1'b0;
        ovf_d = ovf_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (valid_i) begin
            if (frame_start) begin
                dec_d = dec_in;
            end
            if (add_ovf) begin
                ovf_d = 1'b1;
            end
            if (last_sample) begin
                sig_d = sum;
                vld_d = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            dec_q <= CW'(1);
            sig_q <= '0;
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dec_q <= dec_d;
            sig_q <= sig_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    assign sig_o   = sig_q;
    assign valid_o = vld_q;
    assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lia_integrate_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lia_integrate_dump : bench for lia_integrate_dump, 64- and 32-bit sums  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lia_integrate_dump;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [27:0] sig_i = '0;
    logic        valid_i = 1'b0;
    logic [23:0] dec_i = 24'd1;
    logic        clear_i = 1'b0;

    logic [63:0] sig64;
    logic        vld64, ovf64;
    logic [31:0] sig32;
    logic        vld32, ovf32;

    always #5 clk_i = ~clk_i;

    lia_integrate_dump u_dut64 (
        .clk_i(clk_i), .rst_i(rst_i), .sig_i(sig_i), .valid_i(valid_i),
        .dec_i(dec_i), .clear_i(clear_i),
        .sig_o(sig64), .valid_o(vld64), .ovf_o(ovf64)
    );

    lia_integrate_dump #(.WIN(28), .WOUT(32), .CW(24)) u_dut32 (
        .clk_i(clk_i), .rst_i(rst_i), .sig_i(sig_i), .valid_i(valid_i),
        .dec_i(dec_i), .clear_i(clear_i),
        .sig_o(sig32), .valid_o(vld32), .ovf_o(ovf32)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: the current frame is kept as a list of samples and re-summed
    // with exact arithmetic, then wrapped or clamped to the accumulator width.
    logic signed [27:0] smp[$];
    int                 flen = 1;
    logic               ev = 1'b0;
    logic signed [64:0] es64 = '0, es32 = '0;
    logic               eo64 = 1'b0, eo32 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [64:0] add_w(input logic signed [64:0] a,
                                                 input logic signed [64:0] b,
                                                 input int w, output logic o);
        logic signed [64:0] mx, mn, s, t;
        mx = (65'sd1 <<< (w - 1)) - 65'sd1;
        mn = -mx - 65'sd1;
        s  = a + b;
        o  = (s > mx) || (s < mn);
`ifdef LIA_ACC_SAT_EN
        if (s > mx)      t = mx;
        else if (s < mn) t = mn;
        else             t = s;
`else
        t = s <<< (65 - w);
        t = t >>> (65 - w);
`endif
        return t;
    endfunction

    function automatic void fold(input int w, output logic signed [64:0] acc, output logic any_ovf);
        logic signed [64:0] x;
        logic o;
        acc = '0;
        any_ovf = 1'b0;
        foreach (smp[i]) begin
            x = smp[i];
            acc = add_w(acc, x, w, o);
            any_ovf |= o;
        end
    endfunction

    task automatic model_update();
        logic signed [64:0] a64, a32;
        logic o;
        if (rst_i) begin
            smp.delete();
            ev = 1'b0; es64 = '0; es32 = '0; eo64 = 1'b0; eo32 = 1'b0;
        end else if (clear_i) begin
            smp.delete();
            ev = 1'b0; eo64 = 1'b0; eo32 = 1'b0;
        end else begin
            ev = 1'b0;
            if (valid_i) begin
                if (smp.size() == 0) flen = (dec_i == 0) ? 1 : int'(dec_i);
                smp.push_back(sig_i);
                fold(64, a64, o); eo64 |= o;
                fold(32, a32, o); eo32 |= o;
                if (smp.size() == flen) begin
                    ev = 1'b1; es64 = a64; es32 = a32;
                    smp.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        chk("vld64", {63'd0, vld64}, {63'd0, ev});
        chk("sig64", sig64, es64[63:0]);
        chk("ovf64", {63'd0, ovf64}, {63'd0, eo64});
        chk("vld32", {63'd0, vld32}, {63'd0, ev});
        chk("sig32", {32'd0, sig32}, {32'd0, es32[31:0]});
        chk("ovf32", {63'd0, ovf32}, {63'd0, eo32});
    endtask

    task automatic cyc(input logic v, input logic [27:0] s, input logic [23:0] d,
                       input logic c, input logic r);
        valid_i = v; sig_i = s; dec_i = d; clear_i = c; rst_i = r;
        @(posedge clk_i);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        logic [27:0] rs;
        logic [23:0] rd;
        repeat (2) cyc(1'b0, 28'd0, 24'd1, 1'b0, 1'b1);

        // Continuous +100, four samples per frame.
        for (int i = 0; i < 12; i++) cyc(1'b1, 28'd100, 24'd4, 1'b0, 1'b0);
        cyc(1'b0, 28'd0, 24'd4, 1'b0, 1'b0);

        // 5, -7, 2 with two idle cycles between samples.
        cyc(1'b1, 28'd5, 24'd3, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 28'd0, 24'd3, 1'b0, 1'b0);
        cyc(1'b1, -28'sd7, 24'd3, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 28'd0, 24'd3, 1'b0, 1'b0);
        cyc(1'b1, 28'd2, 24'd3, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 28'd0, 24'd3, 1'b0, 1'b0);

        // dec 0 behaves as 1: dump every cycle.
        for (int i = 0; i < 4; i++) cyc(1'b1, 28'hFFF_FFFF, 24'd0, 1'b0, 1'b0);

        // Length change mid-frame takes effect only at the next frame.
        cyc(1'b1, 28'd1, 24'd4, 1'b0, 1'b0);
        cyc(1'b1, 28'd2, 24'd4, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 28'(i + 3), 24'd2, 1'b0, 1'b0);

        // Clear with the third sample aborts the frame.
        cyc(1'b1, 28'd1, 24'd4, 1'b0, 1'b0);
        cyc(1'b1, 28'd1, 24'd4, 1'b0, 1'b0);
        cyc(1'b1, 28'd1, 24'd4, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 28'd1, 24'd4, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 28'd0, 24'd4, 1'b0, 1'b0);

        // Max positive input over 32 samples overflows the 32-bit instance.
        for (int i = 0; i < 32; i++) cyc(1'b1, 28'h7FF_FFFF, 24'd32, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 28'd0, 24'd32, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 28'h800_0000, 24'd20, 1'b0, 1'b0);
        cyc(1'b0, 28'd0, 24'd4, 1'b1, 1'b0);
        cyc(1'b0, 28'd0, 24'd4, 1'b0, 1'b0);

        // Reset mid-frame discards the partial frame.
        cyc(1'b1, 28'd9, 24'd3, 1'b0, 1'b0);
        cyc(1'b1, 28'd9, 24'd3, 1'b0, 1'b0);
        cyc(1'b1, 28'd9, 24'd3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 28'd7, 24'd3, 1'b0, 1'b0);

        // Randomized traffic.
        rd = 24'd5;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       rs = ($urandom_range(0, 1) == 1) ? 28'h7FF_FFFF : 28'h800_0000;
                default: rs = 28'($urandom);
            endcase
            if ($urandom_range(0, 19) == 0) rd = 24'($urandom_range(0, 40));
            cyc($urandom_range(0, 9) < 7, rs, rd,
                $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
